// File: rtl/pmc_dec_pkg.sv
// Shared constants, FSM state encoding and header check for the PMC frame decoder.
package pmc_dec_pkg;

  localparam logic [7:0]  START_BYTE = 8'h0F;
  localparam logic [7:0]  END_BYTE   = 8'hF0;
  localparam logic [15:0] CMD_READ   = 16'h0001;
  localparam logic [15:0] CMD_WRITE  = 16'h0002;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    ADDR = 3'd3,
    ERR  = 3'd4,
    END  = 3'd5,
    REQ  = 3'd6
  } dec_state_t;

  function automatic logic isValidCmd(input logic [15:0] hdr);
    return (hdr == CMD_READ) || (hdr == CMD_WRITE);
  endfunction

endpackage

// File: rtl/pmc_gap_timer.sv
// Saturating inter-byte gap counter; expired holds once LIMIT idle cycles have elapsed.
module pmc_gap_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(LIMIT));

endmodule

// File: rtl/pmc_frame_decoder.sv
// Serial byte-stream frame decoder producing a held read/write request.
// Optional inter-byte timeout enabled by defining PMC_DEC_TIMEOUT_EN.
module pmc_frame_decoder
  import pmc_dec_pkg::*;
#(
  parameter int ADDR_BYTES     = 3,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iRxValid,
  input  logic [7:0]              iRxByte,
  input  logic                    iAck,
  output logic                    oReq_EXT,
  output logic [8*ADDR_BYTES-1:0] oAddr,
  output logic [8*DATA_BYTES-1:0] oData,
  output logic                    oWrite,
  output logic                    oRead,
  output logic                    oError,
  output logic                    oFrameErr,
  output logic                    oDrop,
  output logic [2:0]              oDbgState
);

  // Handshake: iRxValid has no backpressure, one byte per asserted cycle.
  // oReq_EXT stays high with stable fields until the cycle oReq_EXT && iAck;
  // iAck is ignored otherwise, and bytes arriving while a request is pending are dropped.

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int MAXF  = (ADDR_BYTES > DATA_BYTES) ? ((ADDR_BYTES > 2) ? ADDR_BYTES : 2)
                                                   : ((DATA_BYTES > 2) ? DATA_BYTES : 2);
  localparam int CNT_W = $clog2(MAXF + 1);

  dec_state_t       state, nextState;
  logic [CNT_W-1:0] byteCnt, nextCnt;
  logic [15:0]      hdrReg;
  logic [DW-1:0]    dataReg;
  logic [AW-1:0]    addrReg;
  logic [7:0]       errReg;
  logic             frameErrQ, frameErrNext;
  logic             dropQ, dropNext;
  logic             gapExpired;
  logic             inFrame;

  assign inFrame = (state == HDR) || (state == DATA) || (state == ADDR) ||
                   (state == ERR) || (state == END);

`ifdef PMC_DEC_TIMEOUT_EN
  logic gapClear;
  assign gapClear = iRxValid || (state == IDLE) || (state == REQ);

  pmc_gap_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) uGapTimer (
    .clk     (clk),
    .reset   (reset),
    .clear   (gapClear),
    .enable  (inFrame),
    .expired (gapExpired)
  );
`else
  // Without the timer a partial frame waits forever; a negative limit is never legal.
  assign gapExpired = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      byteCnt   <= '0;
      hdrReg    <= '0;
      dataReg   <= '0;
      addrReg   <= '0;
      errReg    <= '0;
      frameErrQ <= 1'b0;
      dropQ     <= 1'b0;
    end else begin
      state     <= nextState;
      byteCnt   <= nextCnt;
      frameErrQ <= frameErrNext;
      dropQ     <= dropNext;
      if (iRxValid) begin
        case (state)
          IDLE: begin
            if (iRxByte == START_BYTE) begin
              hdrReg  <= '0;
              dataReg <= '0;
              addrReg <= '0;
              errReg  <= '0;
            end
          end
          HDR:     hdrReg  <= {hdrReg[7:0], iRxByte};
          DATA:    dataReg <= (dataReg << 8) | DW'(iRxByte);
          ADDR:    addrReg <= (addrReg << 8) | AW'(iRxByte);
          ERR:     errReg  <= iRxByte;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    nextState    = state;
    nextCnt      = byteCnt;
    frameErrNext = 1'b0;
    dropNext     = 1'b0;
    case (state)
      IDLE: begin
        if (iRxValid && (iRxByte == START_BYTE)) begin
          nextState = HDR;
          nextCnt   = '0;
        end
      end
      HDR: begin
        if (iRxValid) begin
          if (byteCnt == CNT_W'(1)) begin
            nextState = DATA;
            nextCnt   = '0;
          end else begin
            nextCnt = byteCnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (iRxValid) begin
          if (byteCnt == CNT_W'(DATA_BYTES - 1)) begin
            nextState = ADDR;
            nextCnt   = '0;
          end else begin
            nextCnt = byteCnt + 1'b1;
          end
        end
      end
      ADDR: begin
        if (iRxValid) begin
          if (byteCnt == CNT_W'(ADDR_BYTES - 1)) begin
            nextState = ERR;
            nextCnt   = '0;
          end else begin
            nextCnt = byteCnt + 1'b1;
          end
        end
      end
      ERR: begin
        if (iRxValid) nextState = END;
      end
      END: begin
        if (iRxValid) begin
          if ((iRxByte == END_BYTE) && isValidCmd(hdrReg)) begin
            nextState = REQ;
          end else begin
            nextState    = IDLE;
            frameErrNext = 1'b1;
          end
        end
      end
      REQ: begin
        dropNext = iRxValid;
        if (iAck) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    // A byte landing on the expiry cycle still counts, so the timeout only wins on idle cycles.
    if (inFrame && !iRxValid && gapExpired) begin
      nextState    = IDLE;
      nextCnt      = '0;
      frameErrNext = 1'b1;
    end
  end

  assign oReq_EXT  = (state == REQ);
  assign oAddr     = oReq_EXT ? addrReg : '0;
  assign oData     = oReq_EXT ? dataReg : '0;
  assign oWrite    = oReq_EXT && (hdrReg == CMD_WRITE);
  assign oRead     = oReq_EXT && (hdrReg == CMD_READ);
  assign oError    = oReq_EXT && (|errReg);
  assign oFrameErr = frameErrQ;
  assign oDrop     = dropQ;
  assign oDbgState = state;

endmodule

// File: tb/tb_pmc_frame_decoder.sv
// Scoreboard bench for pmc_frame_decoder: a frame-level model pushes expected events, a monitor pops them.
module tb_pmc_frame_decoder;

  localparam int AB = 3;
  localparam int DB = 4;
  localparam int AW = 8 * AB;
  localparam int DW = 8 * DB;
  localparam int RW = AW + DW + 3;
`ifdef PMC_DEC_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          clk;
  logic          reset;
  logic          iRxValid;
  logic [7:0]    iRxByte;
  logic          iAck;
  logic          oReq_EXT;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oData;
  logic          oWrite;
  logic          oRead;
  logic          oError;
  logic          oFrameErr;
  logic          oDrop;
  logic [2:0]    oDbgState;

  pmc_frame_decoder #(
    .ADDR_BYTES     (AB),
    .DATA_BYTES     (DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iRxValid  (iRxValid),
    .iRxByte   (iRxByte),
    .iAck      (iAck),
    .oReq_EXT  (oReq_EXT),
    .oAddr     (oAddr),
    .oData     (oData),
    .oWrite    (oWrite),
    .oRead     (oRead),
    .oError    (oError),
    .oFrameErr (oFrameErr),
    .oDrop     (oDrop),
    .oDbgState (oDbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];
  logic [0:0]    ferr_q[$];
  logic [0:0]    drop_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor
  initial begin : monitor
    logic prev_req;
    logic prev_ferr;
    logic [RW-1:0] cur;
    logic [RW-1:0] held;
    prev_req  = 1'b0;
    prev_ferr = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      cur = {oWrite, oRead, oError, oAddr, oData};
      if (oReq_EXT) begin
        if (!prev_req) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got %h expected no request", cur);
            held = cur;
          end else begin
            held = exp_q.pop_front();
            check("req_fields", 64'(cur), 64'(held));
          end
        end else begin
          check("req_hold", 64'(cur), 64'(held));
        end
      end else begin
        check("idle_fields_zero", 64'(cur), 64'd0);
      end
      if (oFrameErr) begin
        if (prev_ferr) check("ferr_pulse_width", 64'd2, 64'd1);
        if (ferr_q.size() == 0) begin
          check("unexpected_ferr", 64'd1, 64'd0);
        end else begin
          void'(ferr_q.pop_front());
          checks++;
        end
      end
      if (oDrop) begin
        if (drop_q.size() == 0) begin
          check("unexpected_drop", 64'd1, 64'd0);
        end else begin
          void'(drop_q.pop_front());
          checks++;
        end
      end
      prev_req  = oReq_EXT;
      prev_ferr = oFrameErr;
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [7:0] b, input logic ack);
    iRxValid = v;
    iRxByte  = b;
    iAck     = ack;
    @(posedge clk);
    #1;
    iRxValid = 1'b0;
    iRxByte  = 8'h00;
    iAck     = 1'b0;
  endtask

  // gap cycles carry random iAck, which must be ignored outside a pending request
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    gap = $urandom_range(0, maxgap);
    repeat (gap) drive(1'b0, 8'h00, 1'($urandom_range(0, 1)));
    drive(1'b1, b, 1'b0);
  endtask

  // reference model: decides the frame outcome purely from its contents
  task automatic expect_frame(input logic [15:0] hdr, input logic [DW-1:0] data,
                              input logic [AW-1:0] addr, input logic [7:0] err,
                              input logic [7:0] endb, output bit good);
    good = (endb == 8'hF0) && ((hdr == 16'h0001) || (hdr == 16'h0002));
    if (good) exp_q.push_back({hdr == 16'h0002, hdr == 16'h0001, err != 8'h00, addr, data});
    else      ferr_q.push_back(1'b1);
  endtask

  task automatic send_frame(input logic [15:0] hdr, input logic [DW-1:0] data,
                            input logic [AW-1:0] addr, input logic [7:0] err,
                            input logic [7:0] endb, input int maxgap);
    send_byte(8'h0F, maxgap);
    send_byte(hdr[15:8], maxgap);
    send_byte(hdr[7:0], maxgap);
    for (int i = DB - 1; i >= 0; i--) send_byte(data[8*i +: 8], maxgap);
    for (int i = AB - 1; i >= 0; i--) send_byte(addr[8*i +: 8], maxgap);
    send_byte(err, maxgap);
    send_byte(endb, maxgap);
  endtask

  task automatic wait_req();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (oReq_EXT) begin
        seen = 1'b1;
        break;
      end
      drive(1'b0, 8'h00, 1'b0);
    end
    check("req_arrives", 64'(seen), 64'd1);
  endtask

  task automatic serve(input int hold, input bit drop_first, input bit drop_on_ack);
    logic v;
    wait_req();
    for (int i = 0; i < hold; i++) begin
      v = (i == 0 && drop_first) ? 1'b1 : 1'($urandom_range(0, 1));
      if (v) drop_q.push_back(1'b1);
      drive(v, 8'($urandom), 1'b0);
    end
    if (drop_on_ack) drop_q.push_back(1'b1);
    drive(drop_on_ack, 8'h0F, 1'b1);
    @(negedge clk);
    check("after_ack_zero", {4'd0, oReq_EXT, oWrite, oRead, oError, oAddr, oData}, 64'd0);
  endtask

  task automatic do_reset();
    // start byte and iAck alongside reset must have no effect
    reset = 1'b1;
    drive(1'b1, 8'h0F, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("reset_outputs_zero",
          {2'd0, oReq_EXT, oFrameErr, oDrop, oWrite, oRead, oError, oAddr, oData}, 64'd0);
  endtask

  task automatic frame_and_serve(input logic [15:0] hdr, input logic [DW-1:0] data,
                                 input logic [AW-1:0] addr, input logic [7:0] err,
                                 input logic [7:0] endb, input int maxgap,
                                 input int hold, input bit drop_first, input bit drop_on_ack);
    bit good;
    expect_frame(hdr, data, addr, err, endb, good);
    send_frame(hdr, data, addr, err, endb, maxgap);
    if (good) serve(hold, drop_first, drop_on_ack);
  endtask

  // stimulus
  initial begin : stimulus
    bit good;
    logic [15:0] hdr;
    logic [7:0]  endb;
    logic [7:0]  junk;
    reset    = 1'b1;
    iRxValid = 1'b0;
    iRxByte  = 8'h00;
    iAck     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_state",
          {2'd0, oReq_EXT, oFrameErr, oDrop, oWrite, oRead, oError, oAddr, oData}, 64'd0);

    // write, read with error, bad end byte, bad header, recovery
    frame_and_serve(16'h0002, 32'hDEADBEEF, 24'h123456, 8'h00, 8'hF0, 0, 5, 1'b0, 1'b0);
    frame_and_serve(16'h0001, 32'h01020304, 24'hABCDEF, 8'h04, 8'hF0, 1, 2, 1'b0, 1'b0);
    frame_and_serve(16'h0002, 32'h11111111, 24'h222222, 8'h00, 8'hAA, 0, 0, 1'b0, 1'b0);
    frame_and_serve(16'h0003, 32'h33333333, 24'h444444, 8'h00, 8'hF0, 0, 0, 1'b0, 1'b0);
    frame_and_serve(16'h0002, 32'hCAFEF00D, 24'h0F0F0F, 8'h00, 8'hF0, 0, 1, 1'b0, 1'b0);

    // leading junk, then drops during the request and on the ack cycle
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    frame_and_serve(16'h0001, 32'h89ABCDEF, 24'h765432, 8'h00, 8'hF0, 0, 3, 1'b1, 1'b1);

    // reset in the middle of the address field
    send_byte(8'h0F, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < DB; i++) send_byte(8'hA5, 0);
    send_byte(8'h77, 0);
    do_reset();
    frame_and_serve(16'h0002, 32'h5555AAAA, 24'h00FF00, 8'h00, 8'hF0, 0, 1, 1'b0, 1'b0);

    // reset while a request is pending
    expect_frame(16'h0001, 32'h0BADF00D, 24'h999999, 8'h01, 8'hF0, good);
    send_frame(16'h0001, 32'h0BADF00D, 24'h999999, 8'h01, 8'hF0, 0);
    wait_req();
    drive(1'b0, 8'h00, 1'b0);
    do_reset();
    frame_and_serve(16'h0001, 32'h00000001, 24'h000002, 8'h00, 8'hF0, 0, 0, 1'b0, 0);

    // stall after the fifth byte
`ifdef PMC_DEC_TIMEOUT_EN
    ferr_q.push_back(1'b1);
`else
    exp_q.push_back({1'b1, 1'b0, 1'b0, 24'h123456, 32'hDEADBEEF});
`endif
    send_byte(8'h0F, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    repeat (20) drive(1'b0, 8'h00, 1'b0);
`ifdef PMC_DEC_TIMEOUT_EN
    check("timeout_to_idle", 64'(oDbgState), 64'd0);
`endif
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    send_byte(8'h00, 0);
    send_byte(8'hF0, 0);
`ifndef PMC_DEC_TIMEOUT_EN
    serve(1, 1'b0, 1'b0);
`endif

    // randomized frames
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom);
        if (junk == 8'h0F) junk = 8'h10;
        send_byte(junk, 1);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: hdr = 16'h0001;
        4, 5, 6, 7: hdr = 16'h0002;
        8:          hdr = 16'h0003;
        default:    hdr = 16'($urandom);
      endcase
      endb = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hF0;
      frame_and_serve(hdr, 32'($urandom), 24'($urandom),
                      ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00, endb, 2,
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) drive(1'b0, 8'h00, 1'b0);
    check("exp_q_empty",  64'(exp_q.size()),  64'd0);
    check("ferr_q_empty", 64'(ferr_q.size()), 64'd0);
    check("drop_q_empty", 64'(drop_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
